// File: rtl/muldiv_if.sv
// Operand/result bus between the EX stage and the multiply/divide unit.
interface muldiv_if #(parameter int WIDTH = 32);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             dz;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, a, b, hi_we, lo_we, wdata,
                    input  busy, done, dz, hi, lo);
    modport slave  (input  start, op, a, b, hi_we, lo_we, wdata,
                    output busy, done, dz, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Optional MULDIV_FAST_MUL_EN: single-cycle combinational multiply path.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    state_t state_q, state_d;

    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   acc_q;    // product high half / partial remainder
    logic [WIDTH-1:0] low_q;    // product low half / quotient
    logic [WIDTH-1:0] m_q;      // multiplicand / divisor magnitude
    logic [WIDTH-1:0] a_raw_q;
    logic             is_div_q, neg_lo_q, neg_hi_q, bz_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             done_q, dz_q;

    logic             accept, sa, sb;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   sum, shl, diff, mul_t, nxt_acc;
    logic [WIDTH-1:0] nxt_low, res_hi, res_lo;
    logic [2*WIDTH-1:0] prod;

    assign accept = (state_q == IDLE) && bus.start;
    assign sa     = bus.a[WIDTH-1] & ~bus.op[0];
    assign sb     = bus.b[WIDTH-1] & ~bus.op[0];
    assign abs_a  = sa ? (~bus.a + 1'b1) : bus.a;
    assign abs_b  = sb ? (~bus.b + 1'b1) : bus.b;

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] ext_a, ext_b, fprod;
    // Sign/zero extension to 2*WIDTH makes one truncated product serve both MULT and MULTU.
    assign ext_a = {{WIDTH{sa}}, bus.a};
    assign ext_b = {{WIDTH{sb}}, bus.b};
    assign fprod = ext_a * ext_b;
`endif

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.start) begin
`ifdef MULDIV_FAST_MUL_EN
                state_d = bus.op[1] ? RUN : FIX;
`else
                state_d = RUN;
`endif
            end
            RUN:  if (cnt_q == CW'(WIDTH)) state_d = FIX;
            FIX:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // One shift-add (multiply) or restoring subtract (divide) step.
    always_comb begin
        sum   = {1'b0, acc_q[WIDTH-1:0]} + {1'b0, m_q};
        shl   = {acc_q[WIDTH-1:0], low_q[WIDTH-1]};
        diff  = shl - {1'b0, m_q};
        mul_t = low_q[0] ? sum : acc_q;
        if (is_div_q) begin
            nxt_acc = diff[WIDTH] ? shl : diff;
            nxt_low = {low_q[WIDTH-2:0], ~diff[WIDTH]};
        end else begin
            nxt_acc = {1'b0, mul_t[WIDTH:1]};
            nxt_low = {mul_t[0], low_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        prod = {acc_q[WIDTH-1:0], low_q};
        if (neg_lo_q) prod = ~prod + 1'b1;
        if (!is_div_q) begin
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end else if (bz_q) begin
            res_hi = a_raw_q;
            res_lo = '1;
        end else begin
            res_hi = neg_hi_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
            res_lo = neg_lo_q ? (~low_q + 1'b1) : low_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            low_q    <= '0;
            m_q      <= '0;
            a_raw_q  <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            bz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.hi_we) hi_q <= bus.wdata;
                    if (bus.lo_we) lo_q <= bus.wdata;
                    if (accept) begin
                        cnt_q    <= '0;
                        dz_q     <= 1'b0;
                        acc_q    <= '0;
                        is_div_q <= bus.op[1];
                        a_raw_q  <= bus.a;
                        bz_q     <= bus.op[1] && (bus.b == '0);
                        neg_lo_q <= sa ^ sb;
                        neg_hi_q <= sa;
                        m_q      <= bus.op[1] ? abs_b : abs_a;
                        low_q    <= bus.op[1] ? abs_a : abs_b;
`ifdef MULDIV_FAST_MUL_EN
                        if (!bus.op[1]) begin
                            acc_q    <= {1'b0, fprod[2*WIDTH-1:WIDTH]};
                            low_q    <= fprod[WIDTH-1:0];
                            neg_lo_q <= 1'b0;
                        end
`endif
                    end
                end
                RUN: if (cnt_q != CW'(WIDTH)) begin
                    acc_q <= nxt_acc;
                    low_q <= nxt_low;
                    cnt_q <= cnt_q + 1'b1;
                end
                FIX: begin
                    hi_q   <= res_hi;
                    lo_q   <= res_lo;
                    dz_q   <= bz_q;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
    assign bus.dz   = dz_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: latency, results, divide-by-zero, MTHI/MTLO and reset.
module tb_muldiv_unit;
    localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 34;
`endif
    localparam int DIV_LAT = 34;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    muldiv_if #(.WIDTH(W)) bus();
    muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns edges from accept to done, whether busy held, and first-cycle dz/hi.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          output int lat, output bit held, output logic dz1, output logic [W-1:0] hi1);
        bit got;
        bus.op = o; bus.a = x; bus.b = y; bus.start = 1'b1;
        @(posedge clk);
        held = 1'b1; got = 1'b0; lat = -1; dz1 = 1'bx; hi1 = 'x;
        for (int j = 1; j <= 100 && !got; j++) begin
            @(negedge clk);
            bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
            if (j == 1) begin dz1 = bus.dz; hi1 = bus.hi; end
            if (bus.done) begin
                got = 1'b1; lat = j - 1;
                if (bus.busy) held = 1'b0;
            end else if (!bus.busy) held = 1'b0;
        end
    endtask

    initial begin
        int lat; bit held; logic dz1; logic [W-1:0] hi1; bit got; bit saw_done;
        bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_dz",   bus.dz,   0);
        chk("rst_hi",   bus.hi,   0);
        chk("rst_lo",   bus.lo,   0);

        run_op(2'b00, 32'hFFFF_FFFD, 32'd7, lat, held, dz1, hi1);
        chk("mult_lat", lat, MUL_LAT);
        chk("mult_busy_held", held, 1);
        chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
        chk("mult_lo", bus.lo, 32'hFFFF_FFEB);

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, held, dz1, hi1);
        chk("multu_hi", bus.hi, 32'hFFFF_FFFE);
        chk("multu_lo", bus.lo, 32'h0000_0001);

        run_op(2'b11, 32'd7, 32'd2, lat, held, dz1, hi1);
        chk("divu_lat", lat, DIV_LAT);
        chk("divu_busy_held", held, 1);
        chk("divu_lo", bus.lo, 3);
        chk("divu_hi", bus.hi, 1);

        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, lat, held, dz1, hi1);
        chk("div_neg_lo", bus.lo, 32'hFFFF_FFFD);
        chk("div_neg_hi", bus.hi, 32'hFFFF_FFFF);

        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, held, dz1, hi1);
        chk("div_ovf_lo", bus.lo, 32'h8000_0000);
        chk("div_ovf_hi", bus.hi, 0);
        chk("div_ovf_dz", bus.dz, 0);

        run_op(2'b11, 32'd5, 32'd0, lat, held, dz1, hi1);
        chk("divu_z_lat", lat, DIV_LAT);
        chk("divu_z_lo", bus.lo, 32'hFFFF_FFFF);
        chk("divu_z_hi", bus.hi, 5);
        chk("divu_z_dz", bus.dz, 1);

        run_op(2'b10, 32'hFFFF_FFF9, 32'd0, lat, held, dz1, hi1);
        chk("div_z_lo", bus.lo, 32'hFFFF_FFFF);
        chk("div_z_hi", bus.hi, 32'hFFFF_FFF9);
        chk("div_z_dz", bus.dz, 1);

        run_op(2'b00, 32'd6, 32'd7, lat, held, dz1, hi1);
        chk("dz_clear_on_accept", dz1, 0);
        chk("mult67_lat", lat, MUL_LAT);
        chk("mult67_lo", bus.lo, 42);
        chk("mult67_hi", bus.hi, 0);

        run_op(2'b10, 32'd42, 32'd6, lat, held, dz1, hi1);
        chk("div42_lat", lat, DIV_LAT);
        chk("div42_lo", bus.lo, 7);
        chk("div42_hi", bus.hi, 0);

        // start + MTHI mid-operation must be ignored
        bus.op = 2'b11; bus.a = 32'd100; bus.b = 32'd7; bus.start = 1'b1;
        @(posedge clk);
        got = 1'b0; lat = -1;
        for (int j = 1; j <= 100 && !got; j++) begin
            @(negedge clk);
            bus.start = 1'b0; bus.hi_we = 1'b0;
            if (j == 5) begin
                bus.start = 1'b1; bus.op = 2'b11; bus.a = 32'd9; bus.b = 32'd3;
                bus.hi_we = 1'b1; bus.wdata = 32'h1234;
            end
            if (j == 7) chk("busy_mthi_ignored", bus.hi, 0);
            if (bus.done) begin got = 1'b1; lat = j - 1; end
        end
        chk("busy_start_lat", lat, DIV_LAT);
        chk("busy_start_lo", bus.lo, 14);
        chk("busy_start_hi", bus.hi, 2);
        @(negedge clk);
        chk("no_queued_op", bus.busy, 0);

        // MTHI in the accepting cycle lands first, result overwrites later
        bus.hi_we = 1'b1; bus.wdata = 32'h77;
        run_op(2'b11, 32'd8, 32'd2, lat, held, dz1, hi1);
        chk("mthi_at_accept", hi1, 32'h77);
        chk("mthi_accept_lo", bus.lo, 4);
        chk("mthi_accept_hi", bus.hi, 0);

        @(negedge clk);
        bus.hi_we = 1'b1; bus.wdata = 32'hABCD;
        @(negedge clk);
        bus.hi_we = 1'b0; bus.lo_we = 1'b1; bus.wdata = 32'h5555;
        @(negedge clk);
        bus.lo_we = 1'b0;
        chk("mthi_idle", bus.hi, 32'hABCD);
        chk("mtlo_idle", bus.lo, 32'h5555);

        // reset in the middle of RUN kills the op
        bus.op = 2'b11; bus.a = 32'd100; bus.b = 32'd7; bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk); bus.start = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre_rst_busy", bus.busy, 1);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_hi", bus.hi, 0);
        chk("midrst_lo", bus.lo, 0);
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done || bus.busy) saw_done = 1'b1;
        end
        chk("midrst_no_done", saw_done, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
